// File: rtl/m_uart_wb.sv
// m_uart_wb: Wishbone UART slave for the midgetv IO space.
// Programmable baud divisor, LSB-first 8N1-style frames of DATABITS bits, RX FIFO, status flags.
// Optional legacy raw-pin mode is compiled in when the macro UART_BITBANG_EN is defined.
module m_uart_wb #(
   parameter int unsigned DIVWIDTH = 16,
   parameter int unsigned DIVRESET = 104,
   parameter int unsigned DATABITS = 8,
   parameter int unsigned RXDEPTH  = 4
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [1:0]  ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK_O,
   input  logic        usartRX,
   output logic        usartTX
);

   localparam int unsigned PtrW = $clog2(RXDEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned BitW = $clog2(DATABITS);

   localparam logic [1:0] AdrData   = 2'd0;
   localparam logic [1:0] AdrStatus = 2'd1;
   localparam logic [1:0] AdrDiv    = 2'd2;
   localparam logic [1:0] AdrCtrl   = 2'd3;

   logic bus_wr, bus_rd;
   logic unused_dat;

   assign ACK_O      = STB_I;
   assign bus_wr     = STB_I & WE_I;
   assign bus_rd     = STB_I & ~WE_I;
   assign unused_dat = ^DAT_I;

   // ---------------------------------------------------------------------------------------------
   // Receive line synchroniser (idles high)
   logic rx_meta_q, rx_sync_q;

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= usartRX;
         rx_sync_q <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Transmit state
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

   tx_state_e           tx_state_q;
   logic [DIVWIDTH-1:0] tx_cnt_q;
   logic [BitW-1:0]     tx_bit_q;
   logic [DATABITS-1:0] tx_shift_q;
   logic                tx_q;
   logic                tx_wr, tx_busy, tx_start, tx_ovf_set, tx_tick;
   logic                bbmode;
   logic [DIVWIDTH-1:0] div_q;

`ifdef UART_BITBANG_EN
   logic bbmode_q, bbtx_q;

   // Raw-pin control register: b0 selects bitbang mode, b1 drives the pin directly
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         bbmode_q <= 1'b0;
         bbtx_q   <= 1'b1;
      end else if (bus_wr && ADR_I == AdrCtrl) begin
         bbmode_q <= DAT_I[0];
         bbtx_q   <= DAT_I[1];
      end
   end

   assign bbmode  = bbmode_q;
   assign usartTX = bbmode_q ? bbtx_q : tx_q;
`else
   assign bbmode  = 1'b0;
   assign usartTX = tx_q;
`endif

   assign tx_wr      = bus_wr && (ADR_I == AdrData) && !bbmode;
   assign tx_busy    = (tx_state_q != TxIdle);
   assign tx_start   = tx_wr && !tx_busy;
   assign tx_ovf_set = tx_wr && tx_busy;
   // >= so that shrinking DIV mid-bit cannot strand the counter past the terminal count
   assign tx_tick    = (tx_cnt_q >= div_q - DIVWIDTH'(1));

   // TX FSM: start bit, DATABITS data bits LSB first, stop bit; each DIV cycles long
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else if (bbmode) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_q       <= 1'b1;
      end else begin
         case (tx_state_q)
            TxIdle: begin
               if (tx_start) begin
                  tx_state_q <= TxStart;
                  tx_cnt_q   <= '0;
                  tx_shift_q <= DAT_I[DATABITS-1:0];
                  tx_q       <= 1'b0;
               end
            end
            TxStart: begin
               if (tx_tick) begin
                  tx_state_q <= TxData;
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
               end else begin
                  tx_cnt_q <= tx_cnt_q + DIVWIDTH'(1);
               end
            end
            TxData: begin
               if (tx_tick) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == BitW'(DATABITS - 1)) begin
                     tx_state_q <= TxStop;
                     tx_q       <= 1'b1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + BitW'(1);
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + DIVWIDTH'(1);
               end
            end
            TxStop: begin
               if (tx_tick) begin
                  tx_state_q <= TxIdle;
                  tx_cnt_q   <= '0;
               end else begin
                  tx_cnt_q <= tx_cnt_q + DIVWIDTH'(1);
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Receive state
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

   rx_state_e           rx_state_q;
   logic [DIVWIDTH-1:0] rx_cnt_q;
   logic [BitW-1:0]     rx_bit_q;
   logic [DATABITS-1:0] rx_shift_q;
   logic                rx_push_q, rx_ferr_q;
   logic                rx_tick, rx_half;

   assign rx_tick = (rx_cnt_q >= div_q - DIVWIDTH'(1));
   assign rx_half = (rx_cnt_q >= (div_q >> 1) - DIVWIDTH'(1));

   // RX FSM: start recheck at DIV/2, then one sample per DIV cycles; push/ferr are 1-cycle pulses
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_push_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_push_q <= 1'b0;
         rx_ferr_q <= 1'b0;
         case (rx_state_q)
            RxIdle: begin
               if (!rx_sync_q) begin
                  rx_state_q <= RxStart;
                  rx_cnt_q   <= '0;
               end
            end
            RxStart: begin
               if (rx_half) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_sync_q ? RxIdle : RxData;
               end else begin
                  rx_cnt_q <= rx_cnt_q + DIVWIDTH'(1);
               end
            end
            RxData: begin
               if (rx_tick) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[DATABITS-1:1]};
                  rx_bit_q   <= rx_bit_q + BitW'(1);
                  if (rx_bit_q == BitW'(DATABITS - 1)) rx_state_q <= RxStop;
               end else begin
                  rx_cnt_q <= rx_cnt_q + DIVWIDTH'(1);
               end
            end
            RxStop: begin
               if (rx_tick) begin
                  rx_cnt_q <= '0;
                  if (rx_sync_q) begin
                     rx_push_q  <= 1'b1;
                     rx_state_q <= RxIdle;
                  end else begin
                     rx_ferr_q  <= 1'b1;
                     rx_state_q <= RxWait;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + DIVWIDTH'(1);
               end
            end
            RxWait: begin
               if (rx_sync_q) rx_state_q <= RxIdle;
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------------
   // RX FIFO
   logic [DATABITS-1:0] fifo_mem [RXDEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     count_q;
   logic                rx_valid, fifo_full, pop, push, rx_ovf_set;

   assign rx_valid   = (count_q != '0);
   assign fifo_full  = (count_q == CntW'(RXDEPTH));
   assign pop        = bus_rd && (ADR_I == AdrData) && rx_valid;
   // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds
   assign push       = rx_push_q && (!fifo_full || pop);
   assign rx_ovf_set = rx_push_q && !push;

   // FIFO storage, no reset needed
   always_ff @(posedge CLK_I) begin
      if (push) fifo_mem[wr_ptr_q] <= rx_shift_q;
   end

   // FIFO pointers and occupancy; pointers wrap naturally since RXDEPTH is a power of 2
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Divisor and sticky flags
   logic                rxovf_q, frameerr_q, txovf_q;
   logic [DIVWIDTH-1:0] div_wr;

   assign div_wr = (DAT_I[DIVWIDTH-1:0] < DIVWIDTH'(2)) ? DIVWIDTH'(2) : DAT_I[DIVWIDTH-1:0];

   // Divisor register and write-1-to-clear error flags; a new event wins over a clear
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         div_q      <= DIVWIDTH'(DIVRESET);
         rxovf_q    <= 1'b0;
         frameerr_q <= 1'b0;
         txovf_q    <= 1'b0;
      end else begin
         if (bus_wr && ADR_I == AdrDiv) div_q <= div_wr;
         if (bus_wr && ADR_I == AdrStatus) begin
            if (DAT_I[2]) rxovf_q    <= 1'b0;
            if (DAT_I[3]) frameerr_q <= 1'b0;
            if (DAT_I[4]) txovf_q    <= 1'b0;
         end
         if (rx_ovf_set) rxovf_q    <= 1'b1;
         if (rx_ferr_q)  frameerr_q <= 1'b1;
         if (tx_ovf_set) txovf_q    <= 1'b1;
      end
   end

   // Read mux; zero whenever the bus is not reading
   always_comb begin
      DAT_O = '0;
      if (bus_rd) begin
         case (ADR_I)
            AdrData: begin
               if (rx_valid) DAT_O[DATABITS-1:0] = fifo_mem[rd_ptr_q];
            end
            AdrStatus: begin
               DAT_O[4:0] = {txovf_q, frameerr_q, rxovf_q, tx_busy, rx_valid};
`ifdef UART_BITBANG_EN
               DAT_O[8] = rx_sync_q;
`endif
            end
            AdrDiv: DAT_O[DIVWIDTH-1:0] = div_q;
`ifdef UART_BITBANG_EN
            AdrCtrl: DAT_O[1:0] = {bbtx_q, bbmode_q};
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_m_uart_wb.sv
// tb_m_uart_wb: directed, table-driven bench for m_uart_wb (default parameters).
module tb_m_uart_wb;

`ifdef UART_BITBANG_EN
   localparam logic [31:0] ST0   = 32'h100;  // synchronised idle-high line shows in STATUS b8
   localparam logic [31:0] CTRL0 = 32'h2;
`else
   localparam logic [31:0] ST0   = 32'h0;
   localparam logic [31:0] CTRL0 = 32'h0;
`endif

   logic        clk, rst, stb, we, ack, tx, loop, rx_drv, rx_line;
   logic [1:0]  adr;
   logic [31:0] dat_i, dat_o, rd;
   int          n_cmp, n_err;

   assign rx_line = loop ? tx : rx_drv;

   m_uart_wb dut (
      .CLK_I   (clk),
      .RST_I   (rst),
      .STB_I   (stb),
      .WE_I    (we),
      .ADR_I   (adr),
      .DAT_I   (dat_i),
      .DAT_O   (dat_o),
      .ACK_O   (ack),
      .usartRX (rx_line),
      .usartTX (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  adr;
      logic [31:0] dat;   // write data, or expected read data
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
      #1;
      check("ack_on_write", {31'b0, ack}, 32'h1);
      check("dat_o_on_write", dat_o, 32'h0);
      @(posedge clk);
      #1;
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      stb = 1'b1; we = 1'b0; adr = a;
      #1;
      d = dat_o;
      @(posedge clk);
      #1;
      stb = 1'b0;
   endtask

   // Drive one frame on the RX line, 4 cycles per bit (DIV=4)
   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (4) @(negedge clk);
      end
      rx_drv = stop;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] pat;
      logic       eb;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_i = '0; loop = 1'b0; rx_drv = 1'b1;

      vecs[0]  = '{we: 1'b0, adr: 2'd2, dat: 32'd104};
      vecs[1]  = '{we: 1'b0, adr: 2'd1, dat: ST0};
      vecs[2]  = '{we: 1'b0, adr: 2'd0, dat: 32'h0};
      vecs[3]  = '{we: 1'b0, adr: 2'd3, dat: CTRL0};
      vecs[4]  = '{we: 1'b1, adr: 2'd2, dat: 32'h1};
      vecs[5]  = '{we: 1'b0, adr: 2'd2, dat: 32'h2};
      vecs[6]  = '{we: 1'b1, adr: 2'd2, dat: 32'h0};
      vecs[7]  = '{we: 1'b0, adr: 2'd2, dat: 32'h2};
      vecs[8]  = '{we: 1'b1, adr: 2'd2, dat: 32'h0001_2345};
      vecs[9]  = '{we: 1'b0, adr: 2'd2, dat: 32'h2345};
      vecs[10] = '{we: 1'b1, adr: 2'd1, dat: 32'h1C};
      vecs[11] = '{we: 1'b0, adr: 2'd1, dat: ST0};
      vecs[12] = '{we: 1'b1, adr: 2'd2, dat: 32'h4};
      vecs[13] = '{we: 1'b0, adr: 2'd2, dat: 32'h4};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx_idle", {31'b0, tx}, 32'h1);
      check("reset_dat_o", dat_o, 32'h0);

      // Register table
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].we) begin
            wb_write(vecs[i].adr, vecs[i].dat);
         end else begin
            wb_read(vecs[i].adr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].dat);
         end
      end

      // TX 0x55 at DIV=4, with an overrun write and busy probes mid-frame
      pat = 8'h55;
      wb_write(2'd0, 32'h55);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         stb = 1'b0; we = 1'b0;
         if (i < 4)        eb = 1'b0;
         else if (i >= 36) eb = 1'b1;
         else              eb = pat[i / 4 - 1];
         check($sformatf("tx_bit_c%0d", i), {31'b0, tx}, {31'b0, eb});
         if (i == 10) begin
            stb = 1'b1; we = 1'b1; adr = 2'd0; dat_i = 32'hA3;
         end
         if (i == 20 || i == 39) begin
            stb = 1'b1; we = 1'b0; adr = 2'd1;
            #1;
            check($sformatf("tx_status_c%0d", i), dat_o, 32'h12 | ST0);
         end
      end
      @(negedge clk);
      stb = 1'b0;
      check("tx_idle_after", {31'b0, tx}, 32'h1);
      wb_read(2'd1, rd);
      check("txbusy_clear_txovf_set", rd, 32'h10 | ST0);
      wb_write(2'd1, 32'h10);
      wb_read(2'd1, rd);
      check("txovf_cleared", rd, ST0);

      // Loopback: five frames into a 4-entry FIFO
      loop = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wb_write(2'd0, 32'h11 + k);
         repeat (44) @(negedge clk);
      end
      wb_read(2'd1, rd);
      check("loop_status_full", rd, 32'h05 | ST0);
      for (int k = 0; k < 4; k++) begin
         wb_read(2'd0, rd);
         check($sformatf("loop_rx%0d", k), rd, 32'h11 + k);
      end
      wb_read(2'd0, rd);
      check("loop_rx_empty", rd, 32'h0);
      wb_read(2'd1, rd);
      check("loop_status_empty", rd, 32'h04 | ST0);
      loop = 1'b0;
      wb_write(2'd1, 32'h1C);

      // Framing error, good frame, glitch
      send_rx(8'h3C, 1'b0);
      repeat (10) @(negedge clk);
      wb_read(2'd1, rd);
      check("frameerr_status", rd, 32'h08 | ST0);
      wb_read(2'd0, rd);
      check("frameerr_fifo_empty", rd, 32'h0);
      wb_write(2'd1, 32'h08);
      send_rx(8'hA5, 1'b1);
      repeat (10) @(negedge clk);
      wb_read(2'd1, rd);
      check("rx_good_status", rd, 32'h01 | ST0);
      wb_read(2'd0, rd);
      check("rx_good_data", rd, 32'hA5);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (60) @(negedge clk);
      wb_read(2'd1, rd);
      check("glitch_status", rd, ST0);
      wb_read(2'd0, rd);
      check("glitch_no_data", rd, 32'h0);

`ifdef UART_BITBANG_EN
      wb_write(2'd3, 32'h1);
      check("bb_tx_low", {31'b0, tx}, 32'h0);
      wb_write(2'd0, 32'hFF);
      wb_read(2'd1, rd);
      check("bb_data_write_ignored", rd, ST0);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      wb_read(2'd1, rd);
      check("bb_rx_sync_low", {31'b0, rd[8]}, 32'h0);
      rx_drv = 1'b1;
      wb_write(2'd3, 32'h2);
      check("bb_tx_released", {31'b0, tx}, 32'h1);
      repeat (60) @(negedge clk);
`else
      wb_write(2'd3, 32'h3);
      wb_read(2'd3, rd);
      check("ctrl_reads_zero", rd, 32'h0);
      check("ctrl_no_effect_tx", {31'b0, tx}, 32'h1);
`endif

      // Reset in the middle of a frame
      wb_write(2'd0, 32'h00);
      repeat (10) @(negedge clk);
      check("midframe_tx_low", {31'b0, tx}, 32'h0);
      rst = 1'b1;
      #1;
      check("reset_abort_tx", {31'b0, tx}, 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      wb_read(2'd2, rd);
      check("reset_div", rd, 32'd104);
      wb_read(2'd1, rd);
      check("reset_status", rd, ST0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
